// File: rtl/gpio_intr_ctrl.sv
// GPIO interrupt controller: synchronizes up to two input channels, latches
// change events into a toggle-on-write ISR and raises a gated level interrupt.
module gpio_intr_ctrl #(
    parameter int C_GPIO_WIDTH  = 32,
    parameter int C_GPIO2_WIDTH = 32,
    parameter int C_IS_DUAL     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C_GPIO_WIDTH-1:0]  gpio_io_i,
    input  logic [C_GPIO2_WIDTH-1:0] gpio2_io_i,
    input  logic                     reg_req,
    input  logic                     reg_we,
    input  logic [1:0]               reg_addr,
    input  logic [31:0]              reg_wdata,
    output logic                     reg_ack,
    output logic [31:0]              reg_rdata,
    output logic                     ip2intc_irpt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] C_ISR_MASK = (C_IS_DUAL != 0) ? 2'b11 : 2'b01;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [C_GPIO_WIDTH-1:0]  r_s1_1, r_s2_1, r_prev_1;
    logic [C_GPIO2_WIDTH-1:0] r_s1_2, r_s2_2, r_prev_2;
    logic [1:0]               r_arm;
    logic                     r_gier;
    logic [1:0]               r_ier;
    logic [1:0]               r_isr;
    logic                     r_ack;
    logic [31:0]              r_rdata;
    logic                     r_irq;

    logic                     w_armed;
    logic                     w_access;
    logic                     w_wr;
    logic [1:0]               w_evt;
    logic [1:0]               w_isr_nxt;
    logic [31:0]              w_data1;
    logic [31:0]              w_rd;
    logic                     w_unused;

    assign w_armed  = (r_arm == 2'd3);
    assign w_access = (r_state == ST_IDLE) && reg_req;
    assign w_wr     = w_access && reg_we;
    assign w_unused = &{1'b0, reg_wdata[30:2]};

    assign w_evt[0] = w_armed && (r_s2_1 != r_prev_1);
    assign w_evt[1] = w_armed && (r_s2_2 != r_prev_2) && (C_IS_DUAL != 0);

    // Access handshake: one ACK per request, then wait for the request to drop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (reg_req) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!reg_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A hardware event is OR-ed in after the toggle so it always wins.
    always_comb begin
        w_isr_nxt = r_isr;
        if (w_wr && (reg_addr == 2'd2)) begin
            w_isr_nxt = r_isr ^ reg_wdata[1:0];
        end else begin
            w_isr_nxt = r_isr;
        end
        w_isr_nxt = (w_isr_nxt | w_evt) & C_ISR_MASK;
    end

    // Register read mux; DATA1 is the synchronized channel-1 level.
    always_comb begin
        w_data1                    = 32'h0;
        w_data1[C_GPIO_WIDTH-1:0]  = r_s2_1;
        case (reg_addr)
            2'd0:    w_rd = {r_gier, 31'h0};
            2'd1:    w_rd = {30'h0, r_ier};
            2'd2:    w_rd = {30'h0, r_isr};
            2'd3:    w_rd = w_data1;
            default: w_rd = 32'h0;
        endcase
    end

    // All state, with reset taking priority over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_s1_1   <= '0;
            r_s2_1   <= '0;
            r_prev_1 <= '0;
            r_s1_2   <= '0;
            r_s2_2   <= '0;
            r_prev_2 <= '0;
            r_arm    <= 2'd0;
            r_gier   <= 1'b0;
            r_ier    <= 2'b00;
            r_isr    <= 2'b00;
            r_ack    <= 1'b0;
            r_rdata  <= 32'h0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1_1   <= gpio_io_i;
            r_s2_1   <= r_s1_1;
            r_prev_1 <= r_s2_1;
            r_s1_2   <= gpio2_io_i;
            r_s2_2   <= r_s1_2;
            r_prev_2 <= r_s2_2;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end else begin
                r_arm <= r_arm;
            end
            if (w_wr && (reg_addr == 2'd0)) begin
                r_gier <= reg_wdata[31];
            end else begin
                r_gier <= r_gier;
            end
            if (w_wr && (reg_addr == 2'd1)) begin
                r_ier <= reg_wdata[1:0] & C_ISR_MASK;
            end else begin
                r_ier <= r_ier;
            end
            r_isr   <= w_isr_nxt;
            r_ack   <= w_access;
            r_rdata <= w_access ? w_rd : 32'h0;
            r_irq   <= r_gier & (|(r_isr & r_ier));
        end
    end

    assign reg_ack      = r_ack;
    assign reg_rdata    = r_rdata;
    assign ip2intc_irpt = r_irq;

endmodule
